// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset PC and fetch FSM states for the 8-bit CPU
package cpu_pkg;
    localparam int ADDR_W = 8;
    localparam int INSTR_W = 24;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;
    typedef enum logic {RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 1- or 2-entry FIFO of {pc, instr}; entry 0 is the head seen by the decoder
module fetch_buf #(
    parameter int DEPTH = 1,
    parameter int W = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [CW-1:0] count_d;
    // shift forward on pop, write the new word right behind the surviving entries
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = (pop && i + 1 < DEPTH) ? mem[(i + 1) % DEPTH] : mem[i];
            if (push && i == int'(count) - int'(pop)) mem_d[i] = din;
        end
        count_d = flush ? '0 : count + CW'(push) - CW'(pop);
    end
    // storage and occupancy registers; flush only clears occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '{default: '0};
            count <= '0;
        end else begin
            mem <= mem_d;
            count <= count_d;
        end
    end
    assign head = mem[0];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, ROM read issue and decoder handshake; FETCH_SKID_EN selects a 2-entry buffer for full-rate fetch
module fetch_unit #(
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    output logic               rom_en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt
);
    import cpu_pkg::*;
`ifdef FETCH_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam int CW = $clog2(CAP + 1);
    fetch_state_t state_q, state_d;
    logic [ADDR_W-1:0] pc, rd_pc;
    logic outstanding, drop, push, pop, can_issue;
    logic [CW-1:0] count;
    logic [ADDR_W+INSTR_W-1:0] head;
    assign pop = instr_valid & instr_ready;
    assign push = outstanding & ~drop;
    assign instr_valid = count != '0;
    assign {instr_pc, instr} = head;
    assign rom_addr = pc;
`ifdef FETCH_SKID_EN
    assign can_issue = CAP - int'(count) - int'(outstanding) + int'(pop) > 0;
`else
    assign can_issue = !outstanding && CAP - int'(count) + int'(pop) > 0;
`endif
    // halt FSM; a fetch goes out only when running, not redirecting and a slot is free
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt) state_d = HALTED;
            HALTED:  if (!halt) state_d = RUN;
            default: state_d = RUN;
        endcase
        rom_en = rst && state_d == RUN && !redirect && can_issue;
    end
    // pc, in-flight read tracking and FSM state; redirect overrides sequential fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pc <= RESET_PC;
            rd_pc <= RESET_PC;
            outstanding <= 1'b0;
            drop <= 1'b0;
        end else begin
            state_q <= state_d;
            outstanding <= rom_en;
            drop <= redirect & outstanding;
            if (rom_en) rd_pc <= pc;
            pc <= redirect ? redirect_pc : rom_en ? pc + 1'b1 : pc;
        end
    end
    fetch_buf #(.DEPTH(CAP), .W(ADDR_W + INSTR_W)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ({rd_pc, rom_data}),
        .head  (head),
        .count (count)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed timing checks plus randomized stream checked against a program-order model
module tb_fetch_unit;
    import cpu_pkg::*;
`ifdef FETCH_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rom_en, instr_valid;
    logic instr_ready = 1'b1;
    logic redirect = 1'b0;
    logic halt = 1'b0;
    logic [ADDR_W-1:0] rom_addr, instr_pc;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic [INSTR_W-1:0] rom_data = '0;
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] rom [256];
    int n_tests = 0;
    int n_fail = 0;
    int xfers = 0;
    logic [ADDR_W-1:0] exp_pc = RESET_PC;
    logic [ADDR_W-1:0] iss_pc = RESET_PC;
    logic [ADDR_W-1:0] hold_pc = '0;
    logic [INSTR_W-1:0] hold_instr = '0;
    logic hold = 1'b0;

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(negedge clk or negedge rst);
        if (!rst) begin
            exp_pc = RESET_PC;
            iss_pc = RESET_PC;
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(instr_valid), 32'(1));
                chk("hold_pc", 32'(instr_pc), 32'(hold_pc));
                chk("hold_instr", 32'(instr), 32'(hold_instr));
            end
            if (halt || redirect) chk("rom_en_gate", 32'(rom_en), 32'(0));
            if (rom_en) begin
                chk("rom_addr", 32'(rom_addr), 32'(iss_pc));
                iss_pc++;
            end
            if (instr_valid && instr_ready) begin
                chk("xfer_pc", 32'(instr_pc), 32'(exp_pc));
                chk("xfer_instr", 32'(instr), 32'(rom[exp_pc]));
                exp_pc++;
                xfers++;
            end
            if (redirect) begin
                exp_pc = redirect_pc;
                iss_pc = redirect_pc;
            end
            hold = instr_valid && !instr_ready && !redirect;
            hold_pc = instr_pc;
            hold_instr = instr;
        end
    end

    initial begin
        int cnt, k, halt_left;
        logic found;
        logic [ADDR_W-1:0] wexp [4];
        for (int n = 0; n < 256; n++) rom[n] = INSTR_W'(n * 3);
        wexp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rom_en", 32'(rom_en), 32'(0));
        chk("rst_rom_addr", 32'(rom_addr), 32'(RESET_PC));
        chk("rst_instr", 32'(instr), 32'(0));
        chk("rst_instr_pc", 32'(instr_pc), 32'(0));
        chk("rst_valid", 32'(instr_valid), 32'(0));
        rst = 1'b1;
        @(negedge clk);
        chk("c0_rom_en", 32'(rom_en), 32'(1));
        chk("c0_rom_addr", 32'(rom_addr), 32'(RESET_PC));
        chk("c0_valid", 32'(instr_valid), 32'(0));
        step;
        @(negedge clk);
        chk("c1_valid", 32'(instr_valid), 32'(0));
        step;
        @(negedge clk);
        chk("c2_valid", 32'(instr_valid), 32'(1));
        chk("c2_pc", 32'(instr_pc), 32'(RESET_PC));
        chk("c2_instr", 32'(instr), 32'(0));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step;
            @(negedge clk);
            if (instr_valid && instr_ready) cnt++;
        end
        chk("throughput", 32'(cnt), 32'(10 * CAP));
        step;
        redirect = 1'b1;
        redirect_pc = 8'h02;
        step;
        redirect = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = rom_en && rom_addr == 8'h05;
            if (!found) step;
        end
        chk("find_05", 32'(found), 32'(1));
        step;
        redirect = 1'b1;
        redirect_pc = 8'h40;
        @(negedge clk);
        chk("redir_rom_en", 32'(rom_en), 32'(0));
        step;
        redirect = 1'b0;
        @(negedge clk);
        chk("r1_valid", 32'(instr_valid), 32'(0));
        chk("r1_rom_en", 32'(rom_en), 32'(1));
        chk("r1_rom_addr", 32'(rom_addr), 32'(8'h40));
        step;
        @(negedge clk);
        chk("r2_valid", 32'(instr_valid), 32'(0));
        step;
        @(negedge clk);
        chk("r3_valid", 32'(instr_valid), 32'(1));
        chk("r3_pc", 32'(instr_pc), 32'(8'h40));
        step;
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        step;
        redirect = 1'b0;
        k = 0;
        for (int i = 0; i < 20 && k < 4; i++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                chk("wrap_pc", 32'(instr_pc), 32'(wexp[k]));
                k++;
            end
            step;
        end
        chk("wrap_cnt", 32'(k), 32'(4));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = rom_en;
            step;
        end
        chk("find_issue", 32'(found), 32'(1));
        halt = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_rom_en", 32'(rom_en), 32'(0));
            if (instr_valid && instr_ready) cnt++;
            step;
        end
        halt = 1'b0;
        chk("halt_delivered", 32'(cnt > 0), 32'(1));
        @(negedge clk);
        chk("resume_rom_en", 32'(rom_en), 32'(1));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = instr_valid;
            if (!found) step;
        end
        chk("find_valid", 32'(found), 32'(1));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'(0));
        chk("mid_rst_rom_en", 32'(rom_en), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        instr_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (rom_en) cnt++;
            if (i == 1) chk("restart_c1_valid", 32'(instr_valid), 32'(0));
            if (i >= 2) begin
                chk("bp_valid", 32'(instr_valid), 32'(1));
                chk("bp_pc", 32'(instr_pc), 32'(RESET_PC));
            end
            step;
        end
        chk("bp_issues", 32'(cnt), 32'(CAP));
        instr_ready = 1'b1;
        k = 0;
        for (int i = 0; i < 20 && k < 3; i++) begin
            @(negedge clk);
            if (instr_valid && instr_ready) begin
                chk("bp_order", 32'(instr_pc), 32'(k));
                k++;
            end
            step;
        end
        chk("bp_cnt", 32'(k), 32'(3));
        cnt = xfers;
        halt_left = 0;
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom % 4) != 0;
            if (halt_left > 0) halt_left--;
            else if ($urandom % 25 == 0) halt_left = 1 + int'($urandom % 5);
            halt = halt_left > 0;
            redirect = ($urandom % 20) == 0;
            redirect_pc = ADDR_W'($urandom);
            step;
        end
        redirect = 1'b0;
        halt = 1'b0;
        instr_ready = 1'b1;
        repeat (5) step;
        chk("random_progress", 32'(xfers - cnt > 50), 32'(1));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
